drlp_rd_gearbox: RTL
====================

// Module: drlp_rd_gearbox
// PURPOSE
//  Parametrised successor of the DMA read buffer: issues sequential DMA reads and repacks a 32-bit stream into
//  K-element output words (K=1..MAX_ELEMS, ELEM_WIDTH bits each, LSB-first, run-time selected per transfer).
//  Credit-based flow control so non-stallable DMA returns never overflow; valid/ready output, zero-padded last word.
//  Sits between the DMA read port and the PE-array input buffer.
// PARAMETERS
//  IN_WIDTH        32  DMA data width; must be a multiple of ELEM_WIDTH
//  ELEM_WIDTH      8   bits per element
//  MAX_ELEMS       8   max elements per output word; OUT_WIDTH = ELEM_WIDTH*MAX_ELEMS
//  DMA_ADDR_WIDTH  32  word address width
//  LEN_WIDTH       16  transfer length (DMA words) width
//  MAX_OUTSTANDING 4   max requests in flight; ACC_W = OUT_WIDTH + MAX_OUTSTANDING*IN_WIDTH
// PORTS
//  i_clk          in   1               clock
//  i_rst          in   1               reset, asynchronous, active-high
//  i_start        in   1               start pulse; sampled only in IDLE
//  i_base_addr    in   DMA_ADDR_WIDTH  first DMA word address
//  i_num_words    in   LEN_WIDTH       DMA words to read
//  i_elems        in   $clog2(MAX_ELEMS+1)  K; 0 or >MAX_ELEMS treated as MAX_ELEMS
//  o_busy         out  1               high RUN..DRAIN
//  o_done         out  1               one-cycle pulse at transfer end
//  o_dma_rd_en    out  1               read request
//  o_dma_rd_addr  out  DMA_ADDR_WIDTH  request address
//  i_dma_rd_ack   in   1               request accepted this cycle
//  i_data_valid   in   1               return data valid (cannot be stalled)
//  i_data         in   IN_WIDTH        return data, in request order
//  o_buf_data     out  OUT_WIDTH       packed word; elements >=K are zero
//  o_buf_valid    out  1               output valid
//  i_buf_ready    in   1               downstream accepts
//  o_buf_last     out  1               final word of transfer, qualified by o_buf_valid
// BEHAVIOUR
//  Reset: all outputs 0, o_dma_rd_addr 0, state IDLE, fill/credits/counters 0. Reset mid-transfer abandons it.
//  One clock; reset is asynchronous and active-high.
//  FSM: IDLE -i_start-> RUN (latch base, len, K; len==0 -> DONE directly, no request issued).
//   RUN: requests while req_left>0; -> DRAIN when all len words returned. DRAIN: emit remaining bits.
//   -> DONE when fill==0 and last word accepted. DONE: o_done=1 one cycle -> IDLE.
//  i_start outside IDLE ignored. i_data_valid in IDLE/DONE dropped (stale returns after reset).
//  Requests: o_dma_rd_en=1 iff RUN, req_left>0, fill+(outstanding+1)*IN_WIDTH <= ACC_W.
//   On en&ack: addr+1, req_left-1, outstanding+1. Return: outstanding-1, data appended at bit[fill].
//   Simultaneous ack+return: outstanding unchanged.
//  Output: valid when fill >= K*ELEM_WIDTH, or in DRAIN with 0<fill<K*ELEM_WIDTH (zero-padded).
//   o_buf_data = acc[K*ELEM_WIDTH-1:0], upper bits 0, registered; holds stable while valid&!ready.
//   On valid&ready: acc >>= K*ELEM_WIDTH, fill -= min(fill,K*ELEM_WIDTH).
//   Same-cycle append+consume: fill' = fill + IN_WIDTH - consumed; appended data lands at post-shift position.
//  Output word count = ceil(len*IN_WIDTH/(K*ELEM_WIDTH)); o_buf_last on exactly the final one.
//  No overflow by construction: assertion fill<=ACC_W, outstanding<=MAX_OUTSTANDING.
// TESTING
//  K=6, len=3, data 03020100,07060504,0B0A0908, ready=1 -> 050403020100, 0B0A09080706(last); done 1 pulse.
//  K=5, len=2, data 03020100,07060504 -> 0403020100, 0000070605(last, zero-padded); 4 requests? no: exactly 2.
//  K=4, len=8, ack every cycle, i_buf_ready=0 -> rd_en drops after credits exhaust; no data lost; then 8 words.
//  len=0, start -> no o_dma_rd_en, no o_buf_valid, o_done one cycle after start.
//  i_rst mid-RUN with 2 outstanding, then returns arrive -> outputs 0, returns dropped, new start clean.
//  K=0 / K=9 with MAX_ELEMS=8 -> behaves as K=8 (64-bit words); i_start while busy ignored.

Source files
------------

// File: rtl/drlp_rd_gearbox_if.sv
// Bundles the DMA read port and the packed-word output port of drlp_rd_gearbox.
//   master: the gearbox side. It drives the read requests and the packed output.
//   slave : the DMA engine / PE-array buffer side.
// Signals:
//   o_dma_rd_en, o_dma_rd_addr   read request and its word address
//   i_dma_rd_ack                 request accepted this cycle
//   i_data_valid, i_data         in-order read returns, which cannot be stalled
//   o_buf_data, o_buf_valid      packed output word and its valid
//   i_buf_ready                  downstream accepts the output word
//   o_buf_last                   final word of the transfer
interface drlp_rd_gearbox_if #(
  parameter int unsigned IN_WIDTH       = 32,
  parameter int unsigned OUT_WIDTH      = 64,
  parameter int unsigned DMA_ADDR_WIDTH = 32
);
  logic                      o_dma_rd_en;
  logic [DMA_ADDR_WIDTH-1:0] o_dma_rd_addr;
  logic                      i_dma_rd_ack;
  logic                      i_data_valid;
  logic [IN_WIDTH-1:0]       i_data;
  logic [OUT_WIDTH-1:0]      o_buf_data;
  logic                      o_buf_valid;
  logic                      i_buf_ready;
  logic                      o_buf_last;

  modport master (
    output o_dma_rd_en, o_dma_rd_addr, o_buf_data, o_buf_valid, o_buf_last,
    input  i_dma_rd_ack, i_data_valid, i_data, i_buf_ready
  );

  modport slave (
    input  o_dma_rd_en, o_dma_rd_addr, o_buf_data, o_buf_valid, o_buf_last,
    output i_dma_rd_ack, i_data_valid, i_data, i_buf_ready
  );
endinterface

// File: rtl/drlp_rd_gearbox.sv
// Sequential DMA reader and stream repacker. It issues len word reads starting at a base
// address. It appends the 32-bit returns LSB-first into an accumulator and emits words of K
// ELEM_WIDTH-bit elements. The final word is zero-padded.
// Credits bound the bits held plus the bits in flight, so returns that cannot be stalled
// never overflow the accumulator.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_start           start pulse, sampled in IDLE only
//   i_base_addr       first DMA word address
//   i_num_words       number of DMA words to read
//   i_elems           K (0 or >MAX_ELEMS selects MAX_ELEMS)
//   o_busy, o_done    busy in RUN/DRAIN; one-cycle done pulse
//   bus (master)      DMA read port plus the valid/ready packed output
module drlp_rd_gearbox #(
  parameter int unsigned IN_WIDTH        = 32,
  parameter int unsigned ELEM_WIDTH      = 8,
  parameter int unsigned MAX_ELEMS       = 8,
  parameter int unsigned DMA_ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_start,
  input  logic [DMA_ADDR_WIDTH-1:0]        i_base_addr,
  input  logic [LEN_WIDTH-1:0]             i_num_words,
  input  logic [$clog2(MAX_ELEMS+1)-1:0]   i_elems,
  output logic                             o_busy,
  output logic                             o_done,
  drlp_rd_gearbox_if.master                bus
);
  localparam int unsigned OUT_WIDTH = ELEM_WIDTH * MAX_ELEMS;
  localparam int unsigned ACC_W     = OUT_WIDTH + MAX_OUTSTANDING * IN_WIDTH;
  localparam int unsigned FILL_W    = $clog2(ACC_W + 1);
  localparam int unsigned OST_W     = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned KW        = $clog2(MAX_ELEMS + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [DMA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]      req_left_q, req_left_d;
  logic [LEN_WIDTH-1:0]      ret_left_q, ret_left_d;
  logic [OST_W-1:0]          outst_q, outst_d;
  logic [FILL_W-1:0]         fill_q, fill_d;
  logic [ACC_W-1:0]          acc_q, acc_d;
  logic [FILL_W-1:0]         kbits_q, kbits_d;

  logic              credit_ok, rd_en, req_fire, ret_fire;
  logic              buf_valid, buf_last, consume;
  logic [FILL_W-1:0] used, fill_sh, fill_nxt;
  logic [ACC_W-1:0]  acc_sh, acc_nxt;
  logic [KW-1:0]     k_sel;

  always_comb begin
    // A new request must fit alongside the held bits and everything already in flight.
    credit_ok = (32'(fill_q) + (32'(outst_q) + 32'd1) * IN_WIDTH) <= ACC_W;
    rd_en     = (state_q == StRun) && (req_left_q != '0) && credit_ok;
    req_fire  = rd_en && bus.i_dma_rd_ack;
    ret_fire  = (state_q == StRun) && bus.i_data_valid;

    buf_valid = ((state_q == StRun) && (fill_q >= kbits_q)) ||
                ((state_q == StDrain) && (fill_q != '0));
    buf_last  = buf_valid && (state_q == StDrain) && (fill_q <= kbits_q);
    consume   = buf_valid && bus.i_buf_ready;

    used    = (fill_q < kbits_q) ? fill_q : kbits_q;
    acc_sh  = consume ? (acc_q >> kbits_q) : acc_q;
    fill_sh = consume ? (fill_q - used) : fill_q;
    // Bits above fill are always zero, so a return can be OR-ed in at the post-shift fill.
    acc_nxt  = ret_fire ? (acc_sh | (ACC_W'(bus.i_data) << fill_sh)) : acc_sh;
    fill_nxt = ret_fire ? (fill_sh + FILL_W'(IN_WIDTH)) : fill_sh;

    k_sel = ((i_elems == '0) || (i_elems > KW'(MAX_ELEMS))) ? KW'(MAX_ELEMS) : i_elems;
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    req_left_d = req_left_q;
    ret_left_d = ret_left_q;
    outst_d    = outst_q;
    fill_d     = fill_q;
    acc_d      = acc_q;
    kbits_d    = kbits_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          addr_d     = i_base_addr;
          req_left_d = i_num_words;
          ret_left_d = i_num_words;
          kbits_d    = FILL_W'(32'(k_sel) * ELEM_WIDTH);
          outst_d    = '0;
          fill_d     = '0;
          acc_d      = '0;
          state_d    = (i_num_words == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        acc_d   = acc_nxt;
        fill_d  = fill_nxt;
        outst_d = outst_q + OST_W'(req_fire) - OST_W'(ret_fire);
        if (req_fire) begin
          addr_d     = addr_q + DMA_ADDR_WIDTH'(1);
          req_left_d = req_left_q - LEN_WIDTH'(1);
        end
        if (ret_fire) begin
          ret_left_d = ret_left_q - LEN_WIDTH'(1);
          if (ret_left_q == LEN_WIDTH'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        acc_d  = acc_nxt;
        fill_d = fill_nxt;
        if (consume && buf_last) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      req_left_q <= '0;
      ret_left_q <= '0;
      outst_q    <= '0;
      fill_q     <= '0;
      acc_q      <= '0;
      kbits_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_left_q <= req_left_d;
      ret_left_q <= ret_left_d;
      outst_q    <= outst_d;
      fill_q     <= fill_d;
      acc_q      <= acc_d;
      kbits_q    <= kbits_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (32'(fill_q) <= ACC_W);
      assert (32'(outst_q) <= MAX_OUTSTANDING);
    end
  end

  always_comb begin
    o_busy            = (state_q == StRun) || (state_q == StDrain);
    o_done            = (state_q == StDone);
    bus.o_dma_rd_en   = rd_en;
    bus.o_dma_rd_addr = addr_q;
    bus.o_buf_valid   = buf_valid;
    bus.o_buf_last    = buf_last;
    // Elements at index K and above read as zero.
    bus.o_buf_data    = '0;
    for (int i = 0; i < int'(OUT_WIDTH); i++) begin
      if (i < int'(kbits_q)) bus.o_buf_data[i] = acc_q[i];
    end
  end
endmodule
